crp16_exec_ctrl: RTL and testbench

Run/step/breakpoint execution controller for the CRP16 datapath on the DE1-SoC. It replaces free-running clock division with a single-cycle clock-enable pulse (step_en) that advances the datapath one cycle per pulse. Three operating modes: free-run at a prescaled rate, single-step from a key, and halt on a PC breakpoint. Sits between the board keys/switches and the datapath clock-enable input; step_count feeds the hex display counter view.

---
 rtl/crp16_exec_ctrl.sv | 122 ++++++++++++
 tb/tb_crp16_exec_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crp16_exec_ctrl.sv
//------------------------------------------------------------------------------
// crp16_exec_ctrl
//   Execution controller for the CRP16 datapath. Produces a single-cycle
//   clock-enable pulse (step_en) that advances the datapath by one cycle.
//   Modes: free-run at a prescaled rate, single-step from a key, and halt
//   when the PC matches a breakpoint address.
//
// Ports
//   clock        system clock (CLOCK_50 domain)
//   reset        asynchronous, active-low reset
//   run_key      raw run/halt toggle request (asynchronous level)
//   step_key     raw single-step request (asynchronous level)
//   bp_en        breakpoint compare enable
//   bp_addr      breakpoint PC value
//   pc           current PC from the datapath
//   step_en      registered one-cycle datapath advance pulse
//   running      high while in RUN
//   halted_at_bp high while stopped at a breakpoint
//   step_count   number of step_en pulses since reset (wraps)
//------------------------------------------------------------------------------
module crp16_exec_ctrl #(
  parameter int unsigned DIV_W  = 24,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_key,
  input  logic              step_key,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              step_en,
  output logic              running,
  output logic              halted_at_bp,
  output logic [15:0]       step_count
);

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  presc, presc_nx;
  logic              bp_skip, bp_skip_nx;
  logic              pulse_nx;

  // [0] first sync stage, [1] sync_q, [2] sync_qq (edge-detect history)
  logic [2:0]        run_sync, step_sync;
  logic              run_edge, step_edge;
  logic              tick, bp_hit;

  assign run_edge  = run_sync[1]  & ~run_sync[2];
  assign step_edge = step_sync[1] & ~step_sync[2];
  assign tick      = &presc;
  // bp_skip lets the instruction at the breakpoint execute once on resume.
  assign bp_hit    = bp_en && (pc == bp_addr) && !bp_skip;

  always_comb begin
    state_nx   = state;
    presc_nx   = presc;
    bp_skip_nx = bp_skip;
    pulse_nx   = 1'b0;
    unique case (state)
      HALT, BREAK: begin
        presc_nx = '0;
        if (run_edge) begin
          state_nx   = RUN;
          bp_skip_nx = 1'b1;
        end else if (step_edge) begin
          state_nx = STEP;
        end
      end
      STEP: begin
        pulse_nx = 1'b1;
        state_nx = HALT;
      end
      RUN: begin
        presc_nx = presc + 1'b1;
        if (run_edge) begin
          state_nx = HALT;
          presc_nx = '0;
        end else if (tick) begin
          if (bp_hit) begin
            state_nx = BREAK;
          end else begin
            pulse_nx   = 1'b1;
            bp_skip_nx = 1'b0;
          end
        end
      end
      default: state_nx = HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= HALT;
      presc        <= '0;
      bp_skip      <= 1'b0;
      run_sync     <= '0;
      step_sync    <= '0;
      step_en      <= 1'b0;
      running      <= 1'b0;
      halted_at_bp <= 1'b0;
      step_count   <= '0;
    end else begin
      run_sync     <= {run_sync[1:0], run_key};
      step_sync    <= {step_sync[1:0], step_key};
      state        <= state_nx;
      presc        <= presc_nx;
      bp_skip      <= bp_skip_nx;
      step_en      <= pulse_nx;
      running      <= (state_nx == RUN);
      halted_at_bp <= (state_nx == BREAK);
      step_count   <= step_count + {15'd0, step_en};
    end
  end

endmodule

// File: tb/tb_crp16_exec_ctrl.sv
module tb_crp16_exec_ctrl;

  localparam int unsigned DIV_W  = 3;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PERIOD = 1 << DIV_W;

  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_BREAK = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              run_key = 1'b0;
  logic              step_key = 1'b0;
  logic              bp_en = 1'b0;
  logic [ADDR_W-1:0] bp_addr = '0;
  logic [ADDR_W-1:0] pc = '0;
  logic              step_en;
  logic              running;
  logic              halted_at_bp;
  logic [15:0]       step_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: key histories as seen through the synchronizers,
  // mode, cycles spent in RUN, skip flag, expected outputs.
  bit          kr1, kr2, kr3, ks1, ks2, ks3;
  int          m_mode;
  int unsigned m_run_cycles;
  bit          m_skip;
  bit          m_en;
  bit [15:0]   m_count;
  int          pulses;

  crp16_exec_ctrl #(.DIV_W(DIV_W), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .run_key      (run_key),
    .step_key     (step_key),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .pc           (pc),
    .step_en      (step_en),
    .running      (running),
    .halted_at_bp (halted_at_bp),
    .step_count   (step_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {kr1, kr2, kr3, ks1, ks2, ks3} = '0;
    m_mode       = M_HALT;
    m_run_cycles = 0;
    m_skip       = 1'b0;
    m_en         = 1'b0;
    m_count      = '0;
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_step();
    bit run_e, step_e, prev_en, tick;
    run_e   = kr2 & ~kr3;
    step_e  = ks2 & ~ks3;
    kr3 = kr2; kr2 = kr1; kr1 = run_key;
    ks3 = ks2; ks2 = ks1; ks1 = step_key;
    prev_en = m_en;
    m_en    = 1'b0;
    case (m_mode)
      M_HALT, M_BREAK: begin
        if (run_e) begin
          m_mode = M_RUN; m_run_cycles = 0; m_skip = 1'b1;
        end else if (step_e) begin
          m_mode = M_STEP;
        end
      end
      M_STEP: begin
        m_en = 1'b1; m_mode = M_HALT;
      end
      default: begin
        tick = (m_run_cycles % PERIOD) == PERIOD - 1;
        m_run_cycles++;
        if (run_e) m_mode = M_HALT;
        else if (tick && bp_en && pc == bp_addr && !m_skip) m_mode = M_BREAK;
        else if (tick) begin
          m_en = 1'b1; m_skip = 1'b0;
        end
      end
    endcase
    m_count = m_count + 16'(prev_en);
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".step_en"}, 32'(step_en), 32'(m_en));
    chk({ctx, ".running"}, 32'(running), 32'(m_mode == M_RUN));
    chk({ctx, ".halted_at_bp"}, 32'(halted_at_bp), 32'(m_mode == M_BREAK));
    chk({ctx, ".step_count"}, 32'(step_count), 32'(m_count));
  endtask

  // One clock: advance model, sample 1 time unit after the edge, compare.
  task automatic cyc(input int n, input string ctx);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      model_step();
      if (step_en === 1'b1) pulses++;
      check_all(ctx);
    end
  endtask

  task automatic press_run();
    run_key = 1'b1; cyc(3, "run_press");
    run_key = 1'b0; cyc(2, "run_release");
  endtask

  task automatic press_step();
    step_key = 1'b1; cyc(3, "step_press");
    step_key = 1'b0; cyc(4, "step_release");
  endtask

  initial begin
    // Reset and idle
    model_reset();
    #12;
    chk("reset.step_en", 32'(step_en), 32'd0);
    chk("reset.step_count", 32'(step_count), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    pulses = 0;
    cyc(50, "idle");
    chk("idle.pulses", 32'(pulses), 32'd0);

    // Single step: key held 20 cycles, pulse 4 cycles after the key rises
    step_key = 1'b1;
    pulses = 0;
    cyc(3, "step_lat");
    chk("step.early", 32'(pulses), 32'd0);
    cyc(1, "step_lat");
    chk("step.at4", 32'(step_en), 32'd1);
    cyc(16, "step_hold");
    step_key = 1'b0;
    cyc(5, "step_after");
    chk("step.pulses", 32'(pulses), 32'd1);
    chk("step.count", 32'(step_count), 32'd1);

    // Free run: 8 pulses in 64 cycles, then stop
    press_run();
    chk("run.running", 32'(running), 32'd1);
    pulses = 0;
    cyc(64, "run");
    chk("run.pulses64", 32'(pulses), 32'd8);
    press_run();
    pulses = 0;
    cyc(30, "stopped");
    chk("stop.pulses", 32'(pulses), 32'd0);
    chk("stop.running", 32'(running), 32'd0);

    // Breakpoint at 0x0005 with pc held there
    bp_en = 1'b1; bp_addr = 16'h0005; pc = 16'h0005;
    pulses = 0;
    press_run();
    cyc(25, "bp_run");
    chk("bp.pulses", 32'(pulses), 32'd1);
    chk("bp.halted", 32'(halted_at_bp), 32'd1);
    pulses = 0;
    press_run();
    cyc(8, "bp_resume");
    chk("bp.resume_pulse", 32'(pulses), 32'd1);
    cyc(16, "bp_again");
    chk("bp.rebreak", 32'(halted_at_bp), 32'd1);
    press_step();
    chk("bp.step_exit", 32'(halted_at_bp), 32'd0);
    bp_en = 1'b0;

    // Simultaneous run+step edges from HALT: run wins, no step pulse
    run_key = 1'b1; step_key = 1'b1;
    pulses = 0;
    cyc(6, "both");
    run_key = 1'b0; step_key = 1'b0;
    chk("both.running", 32'(running), 32'd1);
    chk("both.no_step", 32'(pulses), 32'd0);
    cyc(4, "both_run");
    press_step();
    cyc(20, "run_step_ignored");
    press_run();
    cyc(4, "halt2");

    // Counter wrap: preload 0xFFFF, one more step wraps to 0
    force dut.step_count = 16'hFFFF;
    #1;
    release dut.step_count;
    m_count = 16'hFFFF;
    cyc(2, "preload");
    press_step();
    cyc(2, "wrap");
    chk("wrap.count", 32'(step_count), 32'd0);

    // Randomized key/pc activity against the model
    bp_addr = 16'h0005;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run_key  = ~run_key;
      if ($urandom_range(0, 11) == 0) step_key = ~step_key;
      if ($urandom_range(0, 99) == 0) bp_en    = ~bp_en;
      pc = ($urandom_range(0, 2) == 0) ? 16'h0005 : 16'($urandom_range(0, 7));
      cyc(1, "rand");
    end
    run_key = 1'b0; step_key = 1'b0; bp_en = 1'b0;
    cyc(6, "rand_settle");
    if (m_mode != M_RUN) press_run();
    cyc(12, "pre_reset_run");

    // Asynchronous reset in the middle of RUN
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("areset.step_en", 32'(step_en), 32'd0);
    chk("areset.running", 32'(running), 32'd0);
    chk("areset.halted", 32'(halted_at_bp), 32'd0);
    chk("areset.count", 32'(step_count), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    pulses = 0;
    cyc(20, "post_reset");
    chk("post_reset.pulses", 32'(pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
